dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving storage depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving wait states inserted before acknowledge (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port MREQ, input, 1 bit: access request from core, active high.
REQ-006 SHALL have port WRITE, input, 1 bit: 1 = write, 0 = read; valid while MREQ high.
REQ-007 SHALL have port SIZE, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 SHALL have port DAD, input, 32 bits: byte address.
REQ-009 SHALL have port DDT, inout, 32 bits: write data in from core; read data out from block.
REQ-010 SHALL have port ACKD_n, output, 1 bit: access acknowledge, active low.
REQ-011 SHALL have port ERR, output, 1 bit: misaligned-access flag, high for the acknowledge cycle only.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-013 In IDLE, MREQ=1 at a rising edge (acceptance edge E0) SHALL latch DAD, SIZE, WRITE and, for writes, DDT.
REQ-014 From IDLE at E0 SHALL go to WAIT if WAIT_CYCLES>0, else directly to ACK.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles via down-counter, then go to ACK.
REQ-016 ACK SHALL last exactly one cycle: ACKD_n=0 from edge E0+WAIT_CYCLES to edge E0+WAIT_CYCLES+1; then IDLE.
REQ-017 ACKD_n SHALL be 1 in IDLE and WAIT.
REQ-018 MREQ, DAD, SIZE, WRITE, DDT changes after E0 SHALL be ignored until return to IDLE.
REQ-019 Back-to-back: MREQ=1 at the edge leaving ACK SHALL NOT be accepted; acceptance resumes at the following edge (min one IDLE cycle between ACKs).
REQ-020 Reads: DDT SHALL be driven only during ACK cycle of a read; otherwise high-impedance.
REQ-021 Read data SHALL be right-justified, zero-extended, little-endian: byte = mem byte DAD[1:0]; half = bytes DAD[1]*2..+1; word = full word.
REQ-022 Writes SHALL update the memory at the edge entering ACK, only in the byte lanes selected by SIZE/DAD[1:0], sourced from the low bits of latched DDT.
REQ-023 Word index SHALL be DAD[log2(DEPTH_WORDS)+1:2]; higher bits ignored (address wraps modulo 4*DEPTH_WORDS).
REQ-024 A write followed by a read of the same address SHALL return the new data with no hazard.
REQ-025 ERR SHALL be 0 except as defined under Configuration.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, wait counter 0, ACKD_n=1, ERR=0, DDT high-impedance.
REQ-027 Reset during WAIT or ACK SHALL abort the access; a pending write not yet committed SHALL NOT modify memory.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHECK_EN SHALL select misalignment checking.
REQ-030 With DMEM_MISALIGN_CHECK_EN defined: half with DAD[0]=1 or word with DAD[1:0]!=00 SHALL be acknowledged normally, ERR=1 during ACK, memory unmodified, read DDT=32'h0000_0000.
REQ-031 Without it: misaligned half SHALL use DAD[0] forced 0, word SHALL use DAD[1:0] forced 00; ERR tied 0.

Verification
REQ-032 WAIT_CYCLES=1: word write 0xDEADBEEF @0x10, then word read @0x10 -> ACKD_n low exactly 2 cycles after each acceptance edge; read DDT=0xDEADBEEF.
REQ-033 Byte write 0xAA @0x13 over 0x11223344, then word read @0x10 -> 0xAA223344; byte read @0x12 -> 0x00000022; half read @0x12 -> 0x0000AA22.
REQ-034 WAIT_CYCLES=0, MREQ held high continuously with reads @0x0,0x4 -> ACKs spaced 2 cycles apart, one IDLE gap, each ACK one cycle wide.
REQ-035 Assert rst_n=0 during WAIT of word write 0x55555555 @0x20 (previously 0x0) -> ACKD_n=1 immediately, DDT Z; later read @0x20 returns 0x00000000.
REQ-036 Word write @0x22: with DMEM_MISALIGN_CHECK_EN -> ERR=1 in ACK, mem @0x20 unchanged; without -> ERR=0, mem @0x20 written.

Source files
------------

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Data-memory slave for a simple core bus. It accepts one access per
//   request and inserts WAIT_CYCLES wait states. It then acknowledges for
//   exactly one cycle, with ACKD_n active low. Storage is four byte-lane RAMs
//   with registered reads. Writes are merged by byte enable. Read data is
//   returned right-justified and zero-extended.
//
// Parameters:
//   DEPTH_WORDS  storage depth in 32-bit words (power of two, 16..65536)
//   WAIT_CYCLES  wait states between acceptance and acknowledge (0..15)
//
// Ports:
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset (memory contents kept)
//   MREQ    in   access request, active high
//   WRITE   in   1 = write, 0 = read
//   SIZE    in   00 byte, 01 halfword, 10/11 word
//   DAD     in   byte address (wraps modulo 4*DEPTH_WORDS)
//   DDT     io   write data in; read data out during a read acknowledge
//   ACKD_n  out  acknowledge, active low, one cycle wide
//   ERR     out  misaligned-access flag, high for the acknowledge cycle only
//
// Build option:
//   DMEM_MISALIGN_CHECK_EN  when defined, misaligned halfword and word
//                           accesses are acknowledged with ERR=1. They leave
//                           memory untouched and read as zero. When undefined,
//                           the low address bits are forced to alignment and
//                           ERR stays 0.
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        ERR
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [AW+1:0]   addr_q;
  logic [1:0]      size_q;
  logic            write_q;
  logic [31:0]     wdata_q;
  logic            ackd_n_q;
  logic            err_q;
  logic            oe_q;
  logic [7:0]      rd_lane_q [4];

  // Byte offset actually used inside the word: halfwords and words are
  // forced to their natural alignment.
  function automatic logic [1:0] lane_off(input logic [1:0] a, input logic [1:0] s);
    case (s)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] s);
    return ((s == 2'b01) && a[0]) || (s[1] && (a != 2'b00));
  endfunction

  // ---------------------------------------------------------------------------
  // Effective access. In IDLE the live bus is used. This only matters when
  // WAIT_CYCLES=0 and the commit happens on the acceptance edge itself.
  // Afterwards the latched copy is used, so bus changes are ignored.
  // ---------------------------------------------------------------------------
  logic            in_idle;
  logic [AW+1:0]   eff_addr;
  logic [1:0]      eff_size;
  logic            eff_write;
  logic [31:0]     eff_wdata;
  logic [AW-1:0]   eff_idx;
  logic [1:0]      eff_off;
  logic            eff_err;
  logic [3:0]      eff_be;
  logic [31:0]     eff_wlanes;
  logic            enter_ack;
  logic            commit;
  logic [3:0]      lane_we;
  logic            rd_en;
  logic            unused_dad;

  assign in_idle   = (state_q == IDLE);
  assign eff_addr  = in_idle ? DAD[AW+1:0] : addr_q;
  assign eff_size  = in_idle ? SIZE        : size_q;
  assign eff_write = in_idle ? WRITE       : write_q;
  assign eff_wdata = in_idle ? DDT         : wdata_q;
  assign eff_idx   = eff_addr[AW+1:2];
  assign eff_off   = lane_off(eff_addr[1:0], eff_size);

  // Address bits above the storage range are deliberately ignored (wrap).
  assign unused_dad = ^DAD[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign eff_err = misaligned(eff_addr[1:0], eff_size);
`else
  assign eff_err = 1'b0;
`endif

  always_comb begin
    eff_be     = 4'hF;
    eff_wlanes = eff_wdata;
    case (eff_size)
      2'b00: begin
        eff_be     = 4'b0001 << eff_off;
        eff_wlanes = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        eff_be     = 4'b0011 << eff_off;
        eff_wlanes = {2{eff_wdata[15:0]}};
      end
      default: begin
        eff_be     = 4'hF;
        eff_wlanes = eff_wdata;
      end
    endcase
    if (eff_err) eff_be = 4'h0;
  end

  // Edge that enters ACK: the only edge where memory is written or read.
  assign enter_ack = (in_idle && MREQ && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
  // Gated by rst_n so an access aborted by reset never commits.
  assign commit  = rst_n && enter_ack;
  assign lane_we = {4{commit && eff_write}} & eff_be;
  assign rd_en   = commit && !eff_write;

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane, registered read, never reset.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (lane_we[gi]) mem_q[eff_idx] <= eff_wlanes[gi*8 +: 8];
      if (rd_en)       rd_lane_q[gi] <= mem_q[eff_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
      ackd_n_q <= 1'b1;
      err_q    <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MREQ) begin
            addr_q  <= DAD[AW+1:0];
            size_q  <= SIZE;
            write_q <= WRITE;
            wdata_q <= WRITE ? DDT : 32'h0;
            if (WAIT_CYCLES == 0) begin
              state_q  <= ACK;
              ackd_n_q <= 1'b0;
              err_q    <= eff_err;
              oe_q     <= !eff_write;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q  <= ACK;
            cnt_q    <= 4'd0;
            ackd_n_q <= 1'b0;
            err_q    <= eff_err;
            oe_q     <= !eff_write;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q  <= IDLE;
          ackd_n_q <= 1'b1;
          err_q    <= 1'b0;
          oe_q     <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= 4'd0;
          ackd_n_q <= 1'b1;
          err_q    <= 1'b0;
          oe_q     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read data formatting from the latched access (stable throughout ACK)
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [1:0]  rd_off;
  logic [31:0] rd_data;

  assign rd_word  = {rd_lane_q[3], rd_lane_q[2], rd_lane_q[1], rd_lane_q[0]};
  assign rd_off   = lane_off(addr_q[1:0], size_q);
  assign rd_shift = rd_word >> {rd_off, 3'b000};

  always_comb begin
    rd_data = rd_word;
    case (size_q)
      2'b00:   rd_data = {24'h0, rd_shift[7:0]};
      2'b01:   rd_data = {16'h0, rd_shift[15:0]};
      default: rd_data = rd_word;
    endcase
    if (err_q) rd_data = 32'h0;
  end

  assign DDT    = oe_q ? rd_data : 32'hzzzz_zzzz;
  assign ACKD_n = ackd_n_q;
  assign ERR    = err_q;

endmodule
